// File: rtl/program_loader.sv
// Framed byte-stream loader: count, {opcode,operand} pairs, checksum -> 16-bit program RAM writes.
// One RAM write per word, one cycle after its low byte; ready drops only for that write cycle.
module program_loader #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic                  o_program_mode,
  output logic [ADDR_WIDTH-1:0] o_program_address,
  output logic [15:0]           o_program_data,
  output logic                  o_write_enable,
  output logic                  o_cpu_reset,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int          CW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE, COUNT, HI, LO, WRITE, CHECK, DONE, ERROR
  } state_t;

  state_t        state;
  logic [CW-1:0] remaining;
  logic [7:0]    sum;
  logic [7:0]    sum_next;
  logic          accept;
  logic          count_bad;

  assign accept    = i_byte_valid && o_byte_ready;
  assign sum_next  = sum + i_byte;
  // A full-depth frame (N == DEPTH) is legal; anything larger cannot fit.
  assign count_bad = (i_byte == 8'd0) || (32'(i_byte) > DEPTH);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state             <= IDLE;
      remaining         <= '0;
      sum               <= '0;
      o_byte_ready      <= 1'b0;
      o_program_mode    <= 1'b0;
      o_program_address <= '0;
      o_program_data    <= '0;
      o_write_enable    <= 1'b0;
      o_cpu_reset       <= 1'b0;
      o_done            <= 1'b0;
      o_error           <= 1'b0;
    end else begin
      o_write_enable <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          // The CPU reset pulse after a good load lasts exactly the first DONE cycle.
          if (state == DONE) o_cpu_reset <= 1'b0;
          if (i_start) begin
            state             <= COUNT;
            o_done            <= 1'b0;
            o_error           <= 1'b0;
            o_program_address <= '0;
            sum               <= '0;
            o_program_mode    <= 1'b1;
            o_cpu_reset       <= 1'b1;
            o_byte_ready      <= 1'b1;
          end
        end
        COUNT: begin
          if (accept) begin
            sum <= sum_next;
            if (count_bad) begin
              state        <= ERROR;
              o_error      <= 1'b1;
              o_byte_ready <= 1'b0;
            end else begin
              remaining <= CW'(i_byte);
              state     <= HI;
            end
          end
        end
        HI: begin
          if (accept) begin
            sum                  <= sum_next;
            o_program_data[15:8] <= i_byte;
            state                <= LO;
          end
        end
        LO: begin
          if (accept) begin
            sum                 <= sum_next;
            o_program_data[7:0] <= i_byte;
            o_byte_ready        <= 1'b0;
            o_write_enable      <= 1'b1;
            state               <= WRITE;
          end
        end
        WRITE: begin
          // Address advances after the strobe, so it wraps to 0 only once CHECK is reached.
          o_program_address <= o_program_address + ADDR_WIDTH'(1);
          remaining         <= remaining - CW'(1);
          o_byte_ready      <= 1'b1;
          state             <= (remaining == CW'(1)) ? CHECK : HI;
        end
        CHECK: begin
          if (accept) begin
            sum          <= sum_next;
            o_byte_ready <= 1'b0;
            if (sum_next == 8'd0) begin
              state          <= DONE;
              o_done         <= 1'b1;
              o_program_mode <= 1'b0;
            end else begin
              // Program mode and CPU reset stay asserted so a corrupt image never runs.
              state   <= ERROR;
              o_error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
